leb128_decoder: RTL
===================

Name: leb128_decoder

Overview:
- Immediate-decode stage between the code ROM byte stream and the CPU execute stage.
- Consumes one bytecode byte per cycle and decodes a WebAssembly LEB128 immediate: unsigned or signed, 32- or 64-bit.
- Presents the value, the number of bytes consumed (so the PC can advance) and a decode error code to the CPU.
- The CPU issues one decode command per immediate-bearing opcode, for example i64.const before a reinterpret.

Parameters:
- USE_64B, 1, enables 64-bit decode; when 0, wide commands are rejected with ERR_NO64.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  decode request
- cmd_ready  out  1  decoder idle and able to accept a request
- cmd_signed  in  1  1 = signed LEB128 (sLEB), 0 = unsigned
- cmd_wide  in  1  1 = 64-bit target, 0 = 32-bit target
- in_data  in  8  bytecode byte
- in_valid  in  1  in_data valid
- in_ready  out  1  decoder accepts in_data this cycle
- out_data  out  64  decoded value
- out_count  out  4  bytes consumed, 0..10
- out_error  out  2  ERR_NONE / ERR_OVERLONG / ERR_PAD / ERR_NO64
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result

Behaviour:
- Reset (reset low, asynchronous): state IDLE; cmd_ready=1, in_ready=0, out_valid=0, out_data=0, out_count=0, out_error=ERR_NONE; accumulator, shift and byte count cleared.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - cmd_ready=1.
  - cmd_valid latches signed/wide and clears the accumulator, shift and count.
  - If cmd_wide && !USE_64B: go to DONE with out_error=ERR_NO64, out_count=0, out_data=0; no bytes are consumed.
  - Otherwise go to ACCUM.
- ACCUM, per byte accepted (in_valid && in_ready):
  - in_ready=1 for the whole state.
  - acc |= in_data[6:0] << (7*count); count++.
  - Limit N = 5 (32-bit) or 10 (64-bit).
  - Byte with bit7=1 and count<N: stay in ACCUM.
  - Byte with bit7=1 and count==N: go to DONE with ERR_OVERLONG.
  - Byte with bit7=0: final byte. Run the padding check, then go to DONE.
- Padding check, applied only when the final byte is byte N:
  - u32: bits[6:4] must be 0.
  - s32: bits[6:4] must all equal bit3.
  - u64: bits[6:1] must be 0.
  - s64: bits[6:1] must all equal bit0.
  - Violation gives ERR_PAD.
- Sign extension (signed mode, error-free final byte with bit6=1): fill every bit from 7*count up to the target width with 1s.
- Width of out_data:
  - 32-bit results are zero-extended in bits 63:32, signed or not.
  - 64-bit results use the full width.
- Latency: out_valid rises the cycle after the final or erroring byte is accepted. A k-byte immediate with continuous in_valid is presented k+1 cycles after the command is accepted.
- Stalls: in_valid low in ACCUM holds all state, with no timeout.
- DONE:
  - out_valid=1; out_data, out_count and out_error stay stable until out_ready.
  - in_ready=0, cmd_ready=0.
  - out_valid && out_ready: return to IDLE; the result-valid flag clears the next cycle. A new command is accepted from the cycle after that, never in the same cycle.
- Errors: after an error no further bytes are consumed. out_data holds the partial accumulator (ERR_OVERLONG, ERR_PAD) or 0 (ERR_NO64).
- A cmd_valid outside IDLE is ignored. in_valid outside ACCUM is ignored and in_ready stays low.
- Reset asserted mid-operation: immediate return to IDLE with reset values; the partial immediate is discarded.

Decomposition:
- Shared header leb128.vh, alongside cpu.vh:
  - ERR_NONE=2'd0, ERR_OVERLONG=2'd1, ERR_PAD=2'd2, ERR_NO64=2'd3.
  - State encodings IDLE, ACCUM, DONE.
  - Byte limits LEB_MAX32=5 and LEB_MAX64=10.
- The CPU maps ERR_NO64 onto its existing NO_64B trap and the other errors onto a decode trap.
- One sub-module is natural: leb128_pad_check, combinational. Inputs: final byte, count, signed, wide. Output: pad_error plus the sign-fill mask.

Test Plan:
- u32, bytes E5 8E 26 -> out_data=64'h0000_0000_0009_8765 (624485), out_count=3, ERR_NONE; out_valid 4 cycles after the command is accepted.
- s32, bytes C0 BB 78 -> 64'h0000_0000_FFFE_1DC0 (-123456), count 3. The same bytes as s64 -> 64'hFFFF_FFFF_FFFE_1DC0.
- s64, byte 7F -> 64'hFFFF_FFFF_FFFF_FFFF, count 1. s64, bytes 80 80 80 80 80 80 80 80 80 7F -> 64'h8000_0000_0000_0000, count 10.
- u32, bytes FF FF FF FF 0F -> 64'h0000_0000_FFFF_FFFF, ERR_NONE. The same with last byte 1F -> ERR_PAD. Bytes 80 80 80 80 80 -> ERR_OVERLONG at count 5; in_ready stays 0 after that.
- USE_64B=0, cmd_wide=1 -> ERR_NO64, count 0, in_ready never asserts. Hold out_ready=0 for 5 cycles -> outputs stable; after the handshake, cmd_ready returns.
- Reset pulsed low after 2 bytes of E5 8E 26, with in_valid gaps inserted -> IDLE immediately with all outputs at reset values. A new command with byte 00 -> out_data 0, count 1.

Source files
------------

// File: rtl/leb128_pkg.sv
// Shared constants and types for the LEB128 immediate decoder: error codes,
// FSM encodings, byte limits and the registered result record.
package leb128_pkg;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_OVERLONG = 2'd1;
  localparam logic [1:0] ERR_PAD      = 2'd2;
  localparam logic [1:0] ERR_NO64     = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [3:0] LEB_MAX32 = 4'd5;
  localparam logic [3:0] LEB_MAX64 = 4'd10;

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  count;
    logic [1:0]  error;
  } leb_result_t;

  function automatic logic [3:0] leb_limit(input logic wide);
    return wide ? LEB_MAX64 : LEB_MAX32;
  endfunction

  // 32-bit results live in the low word; the upper word is always zero.
  function automatic logic [63:0] width_mask(input logic wide);
    return wide ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

endpackage

// File: rtl/leb128_pad_check.sv
// Combinational check of the unused high bits in the last permitted LEB128 byte,
// plus the ones-mask used to sign-extend a negative signed immediate.
module leb128_pad_check
  import leb128_pkg::*;
(
  input  logic [7:0]  final_byte,
  input  logic [3:0]  count,
  input  logic        is_signed,
  input  logic        wide,
  output logic        pad_error,
  output logic [63:0] sign_fill
);

  logic       at_limit;
  logic [6:0] fill_shift;

  assign at_limit   = (count == leb_limit(wide));
  assign fill_shift = 7'(count) * 7'd7;

  // Only byte N can carry bits beyond the target width.
  always_comb begin
    pad_error = 1'b0;
    if (at_limit) begin
      case ({is_signed, wide})
        2'b00:   pad_error = |final_byte[6:4];
        2'b10:   pad_error = (final_byte[6:4] != {3{final_byte[3]}});
        2'b01:   pad_error = |final_byte[6:1];
        default: pad_error = (final_byte[6:1] != {6{final_byte[0]}});
      endcase
    end
  end

  // A shift of 64 or more yields zero, so full-length immediates get no fill.
  always_comb begin
    sign_fill = '0;
    if (is_signed && final_byte[6] && !pad_error) begin
      sign_fill = ({64{1'b1}} << fill_shift) & width_mask(wide);
    end
  end

endmodule

// File: rtl/leb128_decoder.sv
// LEB128 immediate decoder: one command, then one bytecode byte per cycle
// until the final byte or an error, then a held result until consumed.
module leb128_decoder
  import leb128_pkg::*;
#(
  parameter bit USE_64B = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_signed,
  input  logic        cmd_wide,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] out_data,
  output logic [3:0]  out_count,
  output logic [1:0]  out_error,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // All ready/valid outputs depend only on the registered state.
  logic [1:0]  state;
  logic        sgn_q;
  logic        wide_q;
  logic [63:0] acc;
  logic [3:0]  count;
  leb_result_t res;

  logic [3:0]  count_next;
  logic [6:0]  shift;
  logic [63:0] acc_next;
  logic [63:0] wmask;
  logic        pad_error;
  logic [63:0] sign_fill;

  assign count_next = count + 4'd1;
  assign shift      = 7'(count) * 7'd7;
  assign acc_next   = acc | (64'(in_data[6:0]) << shift);
  assign wmask      = width_mask(wide_q);

  leb128_pad_check u_pad_check (
    .final_byte (in_data),
    .count      (count_next),
    .is_signed  (sgn_q),
    .wide       (wide_q),
    .pad_error  (pad_error),
    .sign_fill  (sign_fill)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      sgn_q  <= 1'b0;
      wide_q <= 1'b0;
      acc    <= '0;
      count  <= '0;
      res    <= '{data: 64'd0, count: 4'd0, error: ERR_NONE};
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            sgn_q  <= cmd_signed;
            wide_q <= cmd_wide;
            acc    <= '0;
            count  <= '0;
            if (cmd_wide && !USE_64B) begin
              state <= ST_DONE;
              res   <= '{data: 64'd0, count: 4'd0, error: ERR_NO64};
            end else begin
              state <= ST_ACCUM;
            end
          end
        end
        ST_ACCUM: begin
          if (in_valid) begin
            acc   <= acc_next;
            count <= count_next;
            if (in_data[7]) begin
              if (count_next == leb_limit(wide_q)) begin
                state <= ST_DONE;
                res   <= '{data: acc_next & wmask, count: count_next,
                           error: ERR_OVERLONG};
              end
            end else begin
              state <= ST_DONE;
              res   <= '{data: (acc_next | sign_fill) & wmask, count: count_next,
                         error: pad_error ? ERR_PAD : ERR_NONE};
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == ST_IDLE);
  assign in_ready  = (state == ST_ACCUM);
  assign out_valid = (state == ST_DONE);
  assign out_data  = res.data;
  assign out_count = res.count;
  assign out_error = res.error;
  assign dbg_state = state;

endmodule
